// File: rtl/argmax_pkg.sv
// Shared types and helpers for the argmax classifier.
// ARGMAX_MARGIN_EN enables the best-minus-second margin output.
package argmax_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_t;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/argmax_classifier_cmp.sv
// Signed compare-and-update for one candidate element.
// ARGMAX_MARGIN_EN adds tracking of the runner-up value.
module argmax_cmp #(
  parameter int bits = 8,
  parameter int IW   = 4
) (
  input  logic signed [bits-1:0] cand,
  input  logic        [IW-1:0]   cand_idx,
  input  logic signed [bits-1:0] best,
  input  logic        [IW-1:0]   best_idx,
`ifdef ARGMAX_MARGIN_EN
  input  logic signed [bits-1:0] second,
  output logic signed [bits-1:0] second_n,
`endif
  output logic signed [bits-1:0] best_n,
  output logic        [IW-1:0]   best_idx_n
);

  logic gt;

  // Strict compare: ties keep the lower index.
  assign gt         = cand > best;
  assign best_n     = gt ? cand : best;
  assign best_idx_n = gt ? cand_idx : best_idx;

`ifdef ARGMAX_MARGIN_EN
  assign second_n = gt ? best
                  : (cand > second) ? cand : second;
`endif

endmodule

// File: rtl/argmax_classifier.sv
// Sequential argmax over a captured score vector, one compare per clock.
// ARGMAX_MARGIN_EN adds the registered margin output.
module argmax_classifier
  import argmax_pkg::*;
#(
  parameter  int bits        = 8,
  parameter  int column_size = 10,
  localparam int IW          = idx_width(column_size)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic signed [bits-1:0] x [0:column_size-1],
  output logic        [IW-1:0]   class_idx,
  output logic signed [bits-1:0] max_val,
`ifdef ARGMAX_MARGIN_EN
  output logic        [bits:0]   margin,
`endif
  output logic                   done
);

  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST = CW'(column_size - 1);

  state_t state_q, state_d;
  logic signed [bits-1:0] buf_q [0:column_size-1];
  logic signed [bits-1:0] buf_d [0:column_size-1];
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [bits-1:0] best_q, best_d;
  logic [IW-1:0]          best_idx_q, best_idx_d;
  logic [IW-1:0]          class_idx_q, class_idx_d;
  logic signed [bits-1:0] max_val_q, max_val_d;
  logic                   done_q, done_d;

  logic signed [bits-1:0] cand;
  logic signed [bits-1:0] nb, res_best;
  logic [IW-1:0]          nbi, res_idx;

`ifdef ARGMAX_MARGIN_EN
  localparam logic signed [bits-1:0] MIN_V = {1'b1, {(bits-1){1'b0}}};
  logic signed [bits-1:0] second_q, second_d;
  logic signed [bits-1:0] ns, res_second;
  logic [bits:0]          margin_q, margin_d;
`endif

  always_comb begin
    cand = buf_q[0];
    for (int i = 0; i < column_size; i++)
      if (cnt_q == CW'(i)) cand = buf_q[i];
  end

  argmax_cmp #(.bits(bits), .IW(IW)) u_cmp (
    .cand      (cand),
    .cand_idx  (cnt_q[IW-1:0]),
    .best      (best_q),
    .best_idx  (best_idx_q),
`ifdef ARGMAX_MARGIN_EN
    .second    (second_q),
    .second_n  (ns),
`endif
    .best_n    (nb),
    .best_idx_n(nbi)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (column_size == 1) ? HOLD : SCAN;
      SCAN: if (cnt_q == LAST) state_d = HOLD;
      HOLD: if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done_d = (state_d == HOLD);
  end

  always_comb begin
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    class_idx_d = class_idx_q;
    max_val_d   = max_val_q;
    res_best    = nb;
    res_idx     = nbi;
`ifdef ARGMAX_MARGIN_EN
    second_d    = second_q;
    margin_d    = margin_q;
    res_second  = ns;
`endif
    // Capture cycle seeds the running result with element 0.
    if (state_q == IDLE) begin
      res_best = x[0];
      res_idx  = '0;
`ifdef ARGMAX_MARGIN_EN
      res_second = MIN_V;
`endif
    end
    if (state_q == IDLE && start) begin
      buf_d = x;
      cnt_d = CW'(1);
    end
    if (state_q == SCAN) cnt_d = cnt_q + CW'(1);
    if (state_q != HOLD && state_d != IDLE) begin
      best_d     = res_best;
      best_idx_d = res_idx;
`ifdef ARGMAX_MARGIN_EN
      second_d   = res_second;
`endif
    end
    if (state_q != HOLD && state_d == HOLD) begin
      class_idx_d = res_idx;
      max_val_d   = res_best;
`ifdef ARGMAX_MARGIN_EN
      margin_d = (column_size == 1) ? '0
               : {res_best[bits-1], res_best}
                 - {res_second[bits-1], res_second};
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < column_size; i++) buf_q[i] <= '0;
      cnt_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      class_idx_q <= '0;
      max_val_q   <= '0;
      done_q      <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
      second_q    <= '0;
      margin_q    <= '0;
`endif
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      class_idx_q <= class_idx_d;
      max_val_q   <= max_val_d;
      done_q      <= done_d;
`ifdef ARGMAX_MARGIN_EN
      second_q    <= second_d;
      margin_q    <= margin_d;
`endif
    end
  end

  assign class_idx = class_idx_q;
  assign max_val   = max_val_q;
  assign done      = done_q;
`ifdef ARGMAX_MARGIN_EN
  assign margin    = margin_q;
`endif

endmodule
